// File: rtl/spigot_e_core.sv
// Mixed-radix spigot generator for the digits of e: emits 2 then n_digits fractional digits in base RADIX.
// Each digit is one sweep over a[N_TERMS..2], using a serial restoring divider for every term.
module spigot_e_core #(
  parameter int N_TERMS = 32,
  parameter int RADIX   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_digits,
  output logic [3:0] digit,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       busy,
  output logic       done
);

  localparam int RW = $clog2(N_TERMS);
  localparam int XW = $clog2(RADIX * N_TERMS);
  // i and the partial remainder must reach N_TERMS itself, one bit wider than a stored term
  localparam int IW = $clog2(N_TERMS + 1);
  localparam int CW = $clog2(XW + 1);

  typedef enum logic [2:0] {
    IDLE, INIT, LOAD, DIV, STORE, EMIT, FIN
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      remaining;
  logic [IW-1:0]   i;
  logic [3:0]      carry;
  logic [RW-1:0]   a [2:N_TERMS];
  logic [IW-1:0]   rem;
  logic [XW-1:0]   quo;
  logic [CW-1:0]   cnt;

  logic [RW-1:0]   a_sel;
  logic [XW-1:0]   x;
  logic [IW:0]     rem_sh;
  logic            ge;
  logic [IW-1:0]   rem_nxt;
  logic [XW-1:0]   quo_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = EMIT;
      EMIT:    if (digit_ready) state_nxt = (remaining == 8'd0) ? FIN : LOAD;
      LOAD:    state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = STORE;
      STORE:   state_nxt = (i == IW'(2)) ? EMIT : LOAD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign digit_valid = (state == EMIT);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

  always_comb begin
    a_sel = '0;
    for (int k = 2; k <= N_TERMS; k++)
      if (i == IW'(k)) a_sel = a[k];
  end

  assign x = XW'(RADIX * int'(a_sel) + int'(carry));

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits
  always_comb begin
    rem_sh  = {rem, quo[XW-1]};
    ge      = (rem_sh >= {1'b0, i});
    rem_nxt = ge ? IW'(rem_sh - {1'b0, i}) : rem_sh[IW-1:0];
    quo_nxt = {quo[XW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      i         <= '0;
      carry     <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      digit     <= '0;
      for (int k = 2; k <= N_TERMS; k++) a[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) remaining <= n_digits;
        end
        INIT: begin
          for (int k = 2; k <= N_TERMS; k++) a[k] <= RW'(1);
          digit <= 4'd2;
        end
        EMIT: begin
          if (digit_ready && remaining != 8'd0) begin
            remaining <= remaining - 8'd1;
            carry     <= '0;
            i         <= IW'(N_TERMS);
          end
        end
        LOAD: begin
          quo <= x;
          rem <= '0;
          cnt <= CW'(XW - 1);
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        STORE: begin
          for (int k = 2; k <= N_TERMS; k++)
            if (i == IW'(k)) a[k] <= rem[RW-1:0];
          // quotient is always below RADIX because every a[i] < i
          carry <= quo[3:0];
          if (i == IW'(2)) digit <= quo[3:0];
          else             i     <= i - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spigot_e_core.sv
// Directed bench for spigot_e_core: decimal and hex digit streams, latency, backpressure, reset mid-run.
module tb_spigot_e_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start10, start16;
  logic [7:0] n_digits;
  logic       digit_ready;
  logic [3:0] d10, d16;
  logic       v10, v16, b10, b16, dn10, dn16;

  bit         sel;
  logic [3:0] cur_digit;
  logic       cur_valid, cur_busy, cur_done;

  int n_chk  = 0;
  int n_pass = 0;
  int got[$];

  int e10[$] = '{2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5};
  int e16[$] = '{2,11,7,14,1,5,1,6,2,8};
  int e0[$]  = '{2};

  always #5 clk = ~clk;

  spigot_e_core dut10 (
    .clk(clk), .rst(rst), .start(start10), .n_digits(n_digits),
    .digit(d10), .digit_valid(v10), .digit_ready(digit_ready),
    .busy(b10), .done(dn10)
  );

  spigot_e_core #(.N_TERMS(32), .RADIX(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .n_digits(n_digits),
    .digit(d16), .digit_valid(v16), .digit_ready(digit_ready),
    .busy(b16), .done(dn16)
  );

  always_comb begin
    cur_digit = sel ? d16  : d10;
    cur_valid = sel ? v16  : v10;
    cur_busy  = sel ? b16  : b10;
    cur_done  = sel ? dn16 : dn10;
  end

  task automatic chk(input string tag, input int got_v, input int exp_v);
    n_chk++;
    if (got_v !== exp_v)
      $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
    else
      n_pass++;
  endtask

  task automatic cmp_seq(input string tag, input int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
  endtask

  // Starts a run and records every transfer; optionally stalls on one digit,
  // pulses start while busy, or stops early after a given number of digits.
  task automatic run(input bit s, input logic [7:0] nd, input int bp_idx, input int bp_exp,
                     input int pulse_idx, input int stop_after, output int ndone);
    bit bp_done = 0, pulse_done = 0, fin = 0;
    int nd_cnt = 0, tail = 0, errs;
    got.delete();
    sel = s;
    @(negedge clk);
    n_digits = nd;
    if (s) start16 = 1'b1; else start10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    start16 = 1'b0;
    for (int c = 0; c < 8000 && !fin; c++) begin
      if (cur_done) nd_cnt++;
      if (cur_valid && got.size() == bp_idx && !bp_done) begin
        bp_done = 1;
        digit_ready = 1'b0;
        errs = 0;
        repeat (50) begin
          @(negedge clk);
          if (!cur_valid || cur_digit != 4'(bp_exp) || !cur_busy || cur_done) errs++;
        end
        chk("bp_hold_errors", errs, 0);
        digit_ready = 1'b1;
      end
      if (cur_valid && digit_ready) got.push_back(int'(cur_digit));
      if (!cur_valid && got.size() == pulse_idx && !pulse_done) begin
        pulse_done = 1;
        if (s) start16 = 1'b1; else start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        start16 = 1'b0;
      end
      if (got.size() == stop_after) fin = 1;
      if (nd_cnt > 0) begin
        tail++;
        if (tail > 5) fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("run_timeout", 1, 0);
    ndone = nd_cnt;
  endtask

  initial begin
    int nd, c, errs;
    bit seen;
    rst = 1'b1; start10 = 0; start16 = 0; n_digits = 8'd15; digit_ready = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_digit", d10, 0);
    chk("rst_valid", v10, 0);
    chk("rst_busy", b10 | b16, 0);
    chk("rst_done", dn10, 0);
    rst = 1'b0;
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (b10 || v10 || dn10 || b16) errs++;
    end
    chk("idle_after_rst", errs, 0);

    // latency: first digit two edges after start, second 341 cycles after the first transfer
    n_digits = 8'd1;
    start10 = 1'b1;
    c = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      start10 = 1'b0;
      c++;
      if (v10) break;
    end
    chk("lat_first", c, 2);
    chk("lat_first_digit", d10, 2);
    @(posedge clk);
    c = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      c++;
      if (v10) break;
    end
    chk("lat_second", c, 341);
    chk("lat_second_digit", d10, 7);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (dn10) seen = 1;
    end
    chk("lat_done", seen, 1);

    run(0, 8'd15, -1, 0, -1, 99, nd);
    cmp_seq("dec", e10);
    chk("dec_done_cnt", nd, 1);
    chk("dec_busy_end", b10, 0);

    run(0, 8'd15, 2, 1, 6, 99, nd);
    cmp_seq("bp", e10);
    chk("bp_done_cnt", nd, 1);

    run(1, 8'd9, -1, 0, -1, 99, nd);
    cmp_seq("hex", e16);
    chk("hex_done_cnt", nd, 1);

    run(0, 8'd0, -1, 0, -1, 99, nd);
    cmp_seq("zero", e0);
    chk("zero_done_cnt", nd, 1);

    // abandon a run while digit 5 is being computed
    run(0, 8'd15, -1, 0, -1, 5, nd);
    chk("mid_got", got.size(), 5);
    repeat (16) @(negedge clk);
    chk("mid_busy_before", b10, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_digit", d10, 0);
    chk("mid_rst_valid", v10, 0);
    chk("mid_rst_busy", b10, 0);
    chk("mid_rst_done", dn10, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    errs = 0;
    repeat (400) begin
      @(negedge clk);
      if (b10 || v10 || dn10) errs++;
    end
    chk("mid_quiet", errs, 0);
    run(0, 8'd15, -1, 0, -1, 99, nd);
    cmp_seq("restart", e10);
    chk("restart_done_cnt", nd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
